// File: rtl/exec_pkg.sv
// Shared opcode constants and controller state encoding for the multi-cycle execute unit.
package exec_pkg;

  localparam logic [5:0] OpAdd  = 6'h00;
  localparam logic [5:0] OpSub  = 6'h01;
  localparam logic [5:0] OpAnd  = 6'h02;
  localparam logic [5:0] OpOr   = 6'h03;
  localparam logic [5:0] OpXor  = 6'h04;
  localparam logic [5:0] OpSlt  = 6'h05;
  localparam logic [5:0] OpSltu = 6'h06;
  localparam logic [5:0] OpSll  = 6'h07;
  localparam logic [5:0] OpSrl  = 6'h08;
  localparam logic [5:0] OpSra  = 6'h09;
  localparam logic [5:0] OpMul  = 6'h0e;
  localparam logic [5:0] OpMulu = 6'h16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDone = 2'd2
  } exec_state_e;

  function automatic logic is_mul_op(input logic [5:0] op);
    return (op == OpMul) || (op == OpMulu);
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Radix-2 shift-add multiplier: WIDTH steps on operand magnitudes, sign applied to the
// full 2*WIDTH result. o_done/o_prod are valid during the final step cycle.
module mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_signed,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_prod
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic               r_run;
  logic               r_neg;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_hi_n;
  logic [WIDTH-1:0]   w_lo_n;
  logic [2*WIDTH-1:0] w_full;

  assign w_a_mag = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_b_mag = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;

  // r_lo holds the unconsumed multiplier bits; product low bits shift in from the top.
  assign w_sum  = {1'b0, r_hi} + ({1'b0, r_mcand} & {(WIDTH+1){r_lo[0]}});
  assign w_hi_n = w_sum[WIDTH:1];
  assign w_lo_n = {w_sum[0], r_lo[WIDTH-1:1]};
  assign w_full = {w_hi_n, w_lo_n};

  assign o_done = r_run && (r_cnt == '0);
  assign o_prod = r_neg ? -w_full : w_full;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run   <= 1'b0;
      r_neg   <= 1'b0;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (i_start) begin
      r_run   <= 1'b1;
      r_neg   <= i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
      r_cnt   <= CW'(WIDTH - 1);
      r_mcand <= w_a_mag;
      r_hi    <= '0;
      r_lo    <= w_b_mag;
    end else if (r_run) begin
      r_hi <= w_hi_n;
      r_lo <= w_lo_n;
      if (r_cnt == '0) begin
        r_run <= 1'b0;
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/exec_unit_mc.sv
// Multi-cycle execute unit: single-cycle ALU ops and an iterative full-width multiply
// behind a start/busy/done handshake.
module exec_unit_mc
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IMM_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       ALU_ctr,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  input  logic [IMM_W-1:0] imm16,
  input  logic             ext_op,
  input  logic             ALUsrc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi
);

  localparam int unsigned SHW = $clog2(WIDTH);

  exec_state_e        r_state;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_out;
  logic [WIDTH-1:0]   r_out_hi;

  logic [WIDTH-1:0]   w_imm_ext;
  logic [WIDTH-1:0]   w_b;
  logic [SHW-1:0]     w_shamt;
  logic [WIDTH-1:0]   w_alu;
  logic               w_mul_start;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;

  assign w_imm_ext = {{(WIDTH-IMM_W){ext_op & imm16[IMM_W-1]}}, imm16};
  assign w_b       = ALUsrc ? w_imm_ext : busB;
  assign w_shamt   = w_b[SHW-1:0];

  always_comb begin
    w_alu = '0;
    case (ALU_ctr)
      OpAdd:   w_alu = busA + w_b;
      OpSub:   w_alu = busA - w_b;
      OpAnd:   w_alu = busA & w_b;
      OpOr:    w_alu = busA | w_b;
      OpXor:   w_alu = busA ^ w_b;
      OpSlt:   w_alu = {{(WIDTH-1){1'b0}}, $signed(busA) < $signed(w_b)};
      OpSltu:  w_alu = {{(WIDTH-1){1'b0}}, busA < w_b};
      OpSll:   w_alu = busA << w_shamt;
      OpSrl:   w_alu = busA >> w_shamt;
      OpSra:   w_alu = $unsigned($signed(busA) >>> w_shamt);
      default: w_alu = '0;
    endcase
  end

  assign w_mul_start = (r_state == StIdle) && start && is_mul_op(ALU_ctr);

  mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul_iter (
    .i_clk    (clk),
    .i_rst_n  (reset),
    .i_start  (w_mul_start),
    .i_signed (ALU_ctr == OpMul),
    .i_a      (busA),
    .i_b      (w_b),
    .o_done   (w_mul_done),
    .o_prod   (w_prod)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= StIdle;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_out    <= '0;
      r_out_hi <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_busy <= 1'b1;
            if (is_mul_op(ALU_ctr)) begin
              r_state <= StMul;
            end else begin
              // ALU result is captured on the start edge itself.
              r_state  <= StDone;
              r_done   <= 1'b1;
              r_out    <= w_alu;
              r_out_hi <= '0;
            end
          end
        end
        StMul: begin
          if (w_mul_done) begin
            r_state  <= StDone;
            r_done   <= 1'b1;
            r_out    <= w_prod[WIDTH-1:0];
            r_out_hi <= w_prod[2*WIDTH-1:WIDTH];
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign out    = r_out;
  assign out_hi = r_out_hi;

endmodule

// File: tb/tb_exec_unit_mc.sv
// Bench for exec_unit_mc: cycle-level reference model with a per-cycle compare process,
// plus directed vectors with hand-computed results and latencies.
`timescale 1ns/1ps
module tb_exec_unit_mc;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start   = 1'b0;
  logic [5:0]  alu_ctr = '0;
  logic [31:0] bus_a   = '0;
  logic [31:0] bus_b   = '0;
  logic [15:0] imm     = '0;
  logic        ext_op  = 1'b0;
  logic        alu_src = 1'b0;
  logic        busy, done;
  logic [31:0] out_lo, out_hi;

  exec_unit_mc #(.WIDTH(32), .IMM_W(16)) u_dut (
    .clk(clk), .reset(rst_n), .start(start), .ALU_ctr(alu_ctr), .busA(bus_a), .busB(bus_b),
    .imm16(imm), .ext_op(ext_op), .ALUsrc(alu_src), .busy(busy), .done(done), .out(out_lo),
    .out_hi(out_hi)
  );

  logic       s8_start = 1'b0;
  logic [5:0] s8_op    = '0;
  logic [7:0] s8_a     = '0;
  logic [7:0] s8_b     = '0;
  logic [3:0] s8_imm   = '0;
  logic       s8_ext   = 1'b0;
  logic       s8_src   = 1'b0;
  logic       s8_busy, s8_done;
  logic [7:0] s8_out, s8_hi;

  exec_unit_mc #(.WIDTH(8), .IMM_W(4)) u_dut8 (
    .clk(clk), .reset(rst_n), .start(s8_start), .ALU_ctr(s8_op), .busA(s8_a), .busB(s8_b),
    .imm16(s8_imm), .ext_op(s8_ext), .ALUsrc(s8_src), .busy(s8_busy), .done(s8_done),
    .out(s8_out), .out_hi(s8_hi)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference results straight from the operation definitions.
  function automatic logic [63:0] ref_calc(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] t;
    longint sa, sb;
    t  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      6'h00: t = a + b;
      6'h01: t = a - b;
      6'h02: t = a & b;
      6'h03: t = a | b;
      6'h04: t = a ^ b;
      6'h05: t = (sa < sb) ? 32'd1 : 32'd0;
      6'h06: t = (a < b) ? 32'd1 : 32'd0;
      6'h07: t = a << b[4:0];
      6'h08: t = a >> b[4:0];
      6'h09: t = 32'(sa >>> b[4:0]);
      6'h0e: return 64'(sa * sb);
      6'h16: return {32'h0, a} * {32'h0, b};
      default: t = '0;
    endcase
    return {32'h0, t};
  endfunction

  function automatic logic [31:0] sel_b(input logic src, input logic ext, input logic [15:0] im,
                                        input logic [31:0] b);
    if (!src) return b;
    if (ext) return {{16{im[15]}}, im};
    return {16'h0, im};
  endfunction

  // Model: edge index of accepted start, edge at which the result lands, visible result.
  int          m_e     = 0;
  int          m_start = -10;
  int          m_done  = -10;
  logic [63:0] m_pend  = '0;
  logic [63:0] m_vis   = '0;

  always @(posedge clk or negedge rst_n) begin
    int e, s, d;
    logic [63:0] p;
    if (!rst_n) begin
      m_start <= -10;
      m_done  <= -10;
      m_pend  <= '0;
      m_vis   <= '0;
    end else begin
      e = m_e + 1;
      s = m_start;
      d = m_done;
      p = m_pend;
      if (start && e >= d + 2) begin
        s = e;
        d = e + (((alu_ctr == 6'h0e) || (alu_ctr == 6'h16)) ? 32 : 0);
        p = ref_calc(alu_ctr, bus_a, sel_b(alu_src, ext_op, imm, bus_b));
      end
      m_e     <= e;
      m_start <= s;
      m_done  <= d;
      m_pend  <= p;
      if (e == d) m_vis <= p;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      cmp("rst_busy", 64'(busy), 64'd0);
      cmp("rst_done", 64'(done), 64'd0);
      cmp("rst_result", {out_hi, out_lo}, 64'd0);
      cmp("rst8_state", {46'd0, s8_busy, s8_done, s8_hi, s8_out}, 64'd0);
    end else begin
      cmp("busy", 64'(busy), 64'((m_e >= m_start) && (m_e <= m_done)));
      cmp("done", 64'(done), 64'(m_e == m_done));
      cmp("result", {out_hi, out_lo}, m_vis);
    end
  end

  task automatic run32(input string name, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [15:0] im, input logic ext,
                       input logic src, input int exp_lat, input logic [63:0] exp);
    int k;
    k = 0;
    @(negedge clk);
    #1;
    alu_ctr = op; bus_a = a; bus_b = b; imm = im; ext_op = ext; alu_src = src; start = 1'b1;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      @(negedge clk);
      #1;
      // Operand churn after the start edge must not disturb the result.
      start = 1'b0; bus_a = $urandom; bus_b = $urandom; imm = 16'($urandom);
      alu_ctr = 6'($urandom);
      if (done) k = i;
    end
    cmp({name, "_latency"}, 64'(k), 64'(exp_lat));
    cmp({name, "_value"}, {out_hi, out_lo}, exp);
  endtask

  task automatic run8(input string name, input logic [5:0] op, input logic [7:0] a,
                      input logic [7:0] b, input int exp_lat, input logic [15:0] exp);
    int k;
    k = 0;
    @(negedge clk);
    #1;
    s8_op = op; s8_a = a; s8_b = b; s8_src = 1'b0; s8_start = 1'b1;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      @(negedge clk);
      #1;
      s8_start = 1'b0; s8_a = 8'($urandom); s8_b = 8'($urandom);
      if (s8_done) k = i;
    end
    cmp({name, "_latency"}, 64'(k), 64'(exp_lat));
    cmp({name, "_value"}, 64'({s8_hi, s8_out}), 64'(exp));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    run32("add_wrap", 6'h00, 32'hFFFF_FFFF, 32'h1, 16'h0, 1'b0, 1'b0, 1, 64'h0);
    run32("mul_neg", 6'h0e, 32'hFFFF_FFFD, 32'd7, 16'h0, 1'b0, 1'b0, 33,
          64'hFFFF_FFFF_FFFF_FFEB);
    run32("mulu_max", 6'h16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'h0, 1'b0, 1'b0, 33,
          64'hFFFF_FFFE_0000_0001);
    run32("imm_sext", 6'h00, 32'h0, 32'h1234_5678, 16'h8000, 1'b1, 1'b1, 1, 64'hFFFF_8000);
    run32("imm_zext", 6'h00, 32'h0, 32'h1234_5678, 16'h8000, 1'b0, 1'b1, 1, 64'h0000_8000);
    run32("sub", 6'h01, 32'd5, 32'd7, 16'h0, 1'b0, 1'b0, 1, 64'hFFFF_FFFE);
    run32("and", 6'h02, 32'hF0F0_F0F0, 32'hFF00_FF00, 16'h0, 1'b0, 1'b0, 1, 64'hF000_F000);
    run32("or", 6'h03, 32'hF0F0_F0F0, 32'h0F0F_0000, 16'h0, 1'b0, 1'b0, 1, 64'hFFFF_F0F0);
    run32("xor", 6'h04, 32'hFFFF_0000, 32'h0F0F_0F0F, 16'h0, 1'b0, 1'b0, 1, 64'hF0F0_0F0F);
    run32("slt", 6'h05, 32'hFFFF_FFFF, 32'd1, 16'h0, 1'b0, 1'b0, 1, 64'h1);
    run32("sltu", 6'h06, 32'hFFFF_FFFF, 32'd1, 16'h0, 1'b0, 1'b0, 1, 64'h0);
    run32("sll", 6'h07, 32'd1, 32'd33, 16'h0, 1'b0, 1'b0, 1, 64'h2);
    run32("srl", 6'h08, 32'h8000_0000, 32'd4, 16'h0, 1'b0, 1'b0, 1, 64'h0800_0000);
    run32("sra", 6'h09, 32'h8000_0000, 32'd4, 16'h0, 1'b0, 1'b0, 1, 64'hF800_0000);
    run32("bad_op", 6'h3f, 32'd5, 32'd6, 16'h0, 1'b0, 1'b0, 1, 64'h0);
    run32("mul_imm", 6'h0e, 32'hFFFF_FFFE, 32'h0, 16'hFFFF, 1'b1, 1'b1, 33, 64'h2);
    run32("mul_min", 6'h0e, 32'h8000_0000, 32'd2, 16'h0, 1'b0, 1'b0, 33,
          64'hFFFF_FFFF_0000_0000);

    // Multiply, stray start while busy, then reset mid-flight.
    @(negedge clk);
    #1;
    alu_ctr = 6'h0e; bus_a = 32'd9; bus_b = 32'd9; alu_src = 1'b0; start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    alu_ctr = 6'h00; bus_a = 32'd1; bus_b = 32'd2; start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    cmp("busy_before_reset", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    cmp("async_rst_busy", 64'(busy), 64'd0);
    cmp("async_rst_done", 64'(done), 64'd0);
    cmp("async_rst_result", {out_hi, out_lo}, 64'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    run32("post_rst_mulu", 6'h16, 32'd3, 32'd5, 16'h0, 1'b0, 1'b0, 33, 64'd15);

    run8("sra8", 6'h09, 8'h80, 8'h03, 1, 16'h00F0);
    run8("mul8_min", 6'h0e, 8'h80, 8'h80, 9, 16'h4000);
    run8("mul8_neg", 6'h0e, 8'h80, 8'h01, 9, 16'hFF80);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
